// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and counter datapath.
// Holds the controller state encoding, the display-source select codes
// (also decoded by the datapath), and the number of lap slots.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        RECALL  = 2'd3
    } sw_state_t;

    localparam logic [1:0] DISP_LIVE = 2'd0;
    localparam logic [1:0] DISP_LAP1 = 2'd1;
    localparam logic [1:0] DISP_LAP2 = 2'd2;
    localparam logic [1:0] DISP_LAP3 = 2'd3;

    localparam int NUM_LAPS = 3;

endpackage

// File: rtl/stopwatch_ctrl_recall_timer.sv
// Inactivity timer for lap-recall browsing.
// Counts tick pulses while clr_i is low and flags the tick that completes
// TIMEOUT ticks; the count wraps to zero on that tick.
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   clr_i     hold/force the count to zero (wins over tick_i)
//   tick_i    one-cycle count enable
//   expire_o  one-cycle: this tick completes the timeout
module recall_timer #(
    parameter int TIMEOUT = 300,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic             at_last;

    assign at_last  = (cnt_q == LAST);
    assign expire_o = tick_i && !clr_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = at_last ? '0 : cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller.
// Turns debounced button pulses into run enable, clear strobe, lap-capture
// strobe/slot and display-source select for the counter datapath, and
// provides lap-recall browsing with an inactivity auto-return.
//   clk_50M    system clock
//   reset      synchronous active-high reset
//   btn_start  start/stop toggle pulse
//   btn_lap    lap capture / recall step pulse
//   btn_clear  clear pulse
//   tick_cs    centisecond tick from the datapath prescaler
//   ovf        datapath count wrapped
//   run        count enable
//   clear_dp   one-cycle clear of count and lap registers
//   lap_we     one-cycle lap capture strobe into slot lap_slot
//   lap_slot   slot index for lap_we
//   disp_sel   display source (0 live, 1..3 lap slot)
//   laps_used  number of filled lap slots
//   lap_full   all lap slots filled
module stopwatch_ctrl #(
    parameter int NUM_LAPS       = 3,
    parameter int RECALL_TIMEOUT = 300,
    parameter int TMR_W          = $clog2(RECALL_TIMEOUT + 1)
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       tick_cs,
    input  logic       ovf,
    output logic       run,
    output logic       clear_dp,
    output logic       lap_we,
    output logic [1:0] lap_slot,
    output logic [1:0] disp_sel,
    output logic [1:0] laps_used,
    output logic       lap_full
);

    import stopwatch_pkg::*;

    localparam logic [1:0] LAPS_MAX = 2'(NUM_LAPS);

    sw_state_t  state_q, state_d;
    logic       run_q, clear_dp_q, clear_dp_d, lap_we_q, lap_we_d;
    logic [1:0] lap_slot_q, lap_slot_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic [1:0] laps_used_q, laps_used_d;
    logic       lap_full_q;
    logic       tmr_clr, tmr_expire;

    recall_timer #(
        .TIMEOUT (RECALL_TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_recall_timer (
        .clk_i    (clk_50M),
        .rst_i    (reset),
        .clr_i    (tmr_clr),
        .tick_i   (tick_cs),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        clear_dp_d  = 1'b0;
        lap_we_d    = 1'b0;
        lap_slot_d  = lap_slot_q;
        disp_sel_d  = disp_sel_q;
        laps_used_d = laps_used_q;
        // Timer runs only in RECALL; any button there restarts it, so the
        // count is already zero whenever RECALL is (re)entered.
        tmr_clr     = (state_q != RECALL) || btn_start || btn_lap || btn_clear;

        unique case (state_q)
            IDLE: begin
                disp_sel_d = DISP_LIVE;
                if (btn_clear) begin
                    clear_dp_d  = 1'b1;
                    laps_used_d = '0;
                end else if (btn_start) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                // Clear is ignored here, so start is the top valid button;
                // ovf pauses without consuming a lap press.
                disp_sel_d = DISP_LIVE;
                if (btn_start || ovf) begin
                    state_d = PAUSED;
                end
                if (btn_lap && !btn_start && (laps_used_q < LAPS_MAX)) begin
                    lap_we_d    = 1'b1;
                    lap_slot_d  = laps_used_q;
                    laps_used_d = laps_used_q + 2'd1;
                end
            end
            PAUSED: begin
                disp_sel_d = DISP_LIVE;
                if (btn_clear) begin
                    state_d     = IDLE;
                    clear_dp_d  = 1'b1;
                    laps_used_d = '0;
                end else if (btn_start) begin
                    state_d = RUNNING;
                end else if (btn_lap && (laps_used_q != 2'd0)) begin
                    state_d    = RECALL;
                    disp_sel_d = DISP_LAP1;
                end
            end
            RECALL: begin
                if (btn_clear) begin
                    state_d     = IDLE;
                    clear_dp_d  = 1'b1;
                    laps_used_d = '0;
                    disp_sel_d  = DISP_LIVE;
                end else if (btn_start) begin
                    state_d    = RUNNING;
                    disp_sel_d = DISP_LIVE;
                end else if (btn_lap) begin
                    if (disp_sel_q < laps_used_q) begin
                        disp_sel_d = disp_sel_q + 2'd1;
                    end else begin
                        state_d    = PAUSED;
                        disp_sel_d = DISP_LIVE;
                    end
                end else if (tmr_expire) begin
                    state_d    = PAUSED;
                    disp_sel_d = DISP_LIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            clear_dp_q  <= 1'b0;
            lap_we_q    <= 1'b0;
            lap_slot_q  <= '0;
            disp_sel_q  <= '0;
            laps_used_q <= '0;
            lap_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= (state_d == RUNNING);
            clear_dp_q  <= clear_dp_d;
            lap_we_q    <= lap_we_d;
            lap_slot_q  <= lap_slot_d;
            disp_sel_q  <= disp_sel_d;
            laps_used_q <= laps_used_d;
            lap_full_q  <= (laps_used_d == LAPS_MAX);
        end
    end

    assign run       = run_q;
    assign clear_dp  = clear_dp_q;
    assign lap_we    = lap_we_q;
    assign lap_slot  = lap_slot_q;
    assign disp_sel  = disp_sel_q;
    assign laps_used = laps_used_q;
    assign lap_full  = lap_full_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: the driver applies one input vector
// per cycle, advances a behavioural model and queues the expected outputs;
// the monitor pops one entry after every rising edge and compares.
module tb_stopwatch_ctrl;

    localparam int TIMEOUT = 300;

    logic       clk_50M = 1'b0;
    logic       reset, btn_start, btn_lap, btn_clear, tick_cs, ovf;
    logic       run, clear_dp, lap_we, lap_full;
    logic [1:0] lap_slot, disp_sel, laps_used;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       run;
        logic       cd;
        logic       we;
        logic [1:0] slot;
        logic [1:0] disp;
        logic [1:0] laps;
        logic       full;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    // Model: a stopwatch is "started" once out of idle, either running or
    // stopped; a stopped watch may be viewing a lap (view != 0).
    bit m_started, m_running;
    int m_view, m_laps, m_ticks, m_slot;

    always #5 clk_50M = ~clk_50M;

    stopwatch_ctrl #(
        .NUM_LAPS       (3),
        .RECALL_TIMEOUT (TIMEOUT)
    ) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .btn_clear (btn_clear),
        .tick_cs   (tick_cs),
        .ovf       (ovf),
        .run       (run),
        .clear_dp  (clear_dp),
        .lap_we    (lap_we),
        .lap_slot  (lap_slot),
        .disp_sel  (disp_sel),
        .laps_used (laps_used),
        .lap_full  (lap_full)
    );

    task automatic step(input logic r, input logic s, input logic l,
                        input logic c, input logic t, input logic o,
                        input string nm);
        exp_t e;
        bit   cd, we;
        reset = r; btn_start = s; btn_lap = l; btn_clear = c;
        tick_cs = t; ovf = o;
        cd = 0; we = 0;
        if (r) begin
            m_started = 0; m_running = 0; m_view = 0;
            m_laps = 0; m_ticks = 0; m_slot = 0;
        end else if (!m_started) begin
            if (c) begin cd = 1; m_laps = 0; end
            else if (s) begin m_started = 1; m_running = 1; end
        end else if (m_running) begin
            if (s || o) m_running = 0;
            if (l && !s && m_laps < 3) begin
                we = 1; m_slot = m_laps; m_laps++;
            end
        end else if (m_view == 0) begin
            if (c) begin m_started = 0; m_laps = 0; cd = 1; end
            else if (s) m_running = 1;
            else if (l && m_laps > 0) begin m_view = 1; m_ticks = 0; end
        end else begin
            if (c) begin m_started = 0; m_laps = 0; cd = 1; m_view = 0; end
            else if (s) begin m_running = 1; m_view = 0; end
            else if (l) begin
                if (m_view < m_laps) begin m_view++; m_ticks = 0; end
                else m_view = 0;
            end else if (t) begin
                m_ticks++;
                if (m_ticks == TIMEOUT) begin m_view = 0; m_ticks = 0; end
            end
        end
        e.run  = m_running;
        e.cd   = cd;
        e.we   = we;
        e.slot = 2'(m_slot);
        e.disp = 2'(m_view);
        e.laps = 2'(m_laps);
        e.full = (m_laps == 3);
        e.nm   = nm;
        exp_q.push_back(e);
        @(negedge clk_50M);
    endtask

    task automatic idle(input int n, input logic t, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, t, 0, nm);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_50M);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (run !== e.run || clear_dp !== e.cd || lap_we !== e.we ||
                    (e.we && lap_slot !== e.slot) || disp_sel !== e.disp ||
                    laps_used !== e.laps || lap_full !== e.full) begin
                    errors++;
                    $display("FAIL %s @%0t: got run=%0b clr=%0b we=%0b slot=%0d disp=%0d laps=%0d full=%0b, want run=%0b clr=%0b we=%0b slot=%0d disp=%0d laps=%0d full=%0b",
                             e.nm, $time, run, clear_dp, lap_we, lap_slot, disp_sel,
                             laps_used, lap_full, e.run, e.cd, e.we, e.slot, e.disp,
                             e.laps, e.full);
                end
            end
        end
    end

    // Driver
    initial begin
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 1, 1, 1, 0, "reset_btns");
        idle(2, 0, "reset_hold");

        step(0, 1, 0, 0, 0, 0, "start1");
        idle(3, 1, "running");
        step(0, 1, 0, 0, 0, 0, "start2_pause");
        idle(2, 1, "paused");
        step(0, 1, 0, 0, 0, 0, "start3_run");

        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, "lap_capture");
            idle(9, 0, "lap_gap");
        end
        step(0, 1, 0, 0, 0, 0, "pause_full");
        step(0, 0, 0, 1, 0, 0, "clear_full");
        idle(2, 0, "idle_after_clear");

        step(0, 1, 0, 0, 0, 0, "start_a");
        step(0, 0, 1, 0, 0, 0, "lap_a1");
        idle(3, 0, "gap");
        step(0, 0, 1, 0, 0, 0, "lap_a2");
        step(0, 1, 0, 0, 0, 0, "pause_a");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0, 0, "recall_step");
            idle(2, 0, "recall_hold");
        end
        step(0, 0, 0, 1, 0, 0, "clear_paused");
        idle(2, 0, "idle_b");

        step(0, 1, 0, 0, 0, 0, "start_b");
        step(0, 0, 1, 0, 0, 0, "lap_b1");
        step(0, 0, 1, 0, 0, 0, "lap_b2");
        step(0, 1, 0, 0, 0, 0, "pause_b");
        step(0, 0, 1, 0, 0, 0, "enter_recall");
        idle(TIMEOUT - 1, 1, "recall_wait");
        step(0, 0, 0, 0, 1, 0, "recall_timeout");
        idle(2, 1, "paused_ticks");
        step(0, 0, 1, 0, 0, 0, "enter_recall2");
        idle(TIMEOUT - 2, 1, "recall_wait2");
        step(0, 0, 1, 0, 1, 0, "lap_on_tick299");
        idle(TIMEOUT - 1, 1, "recall_wait3");
        step(0, 0, 0, 0, 1, 0, "recall_timeout2");

        step(0, 1, 0, 0, 0, 0, "start_c");
        step(0, 1, 1, 1, 0, 0, "triple_running");
        step(0, 1, 1, 1, 0, 0, "triple_paused");
        idle(2, 0, "idle_c");

        step(0, 1, 0, 0, 0, 0, "start_d");
        step(0, 0, 1, 0, 0, 1, "ovf_with_lap");
        idle(2, 0, "paused_d");
        step(0, 1, 0, 0, 0, 0, "start_e");
        step(0, 0, 0, 0, 0, 1, "ovf_only");
        step(0, 0, 1, 0, 0, 0, "enter_recall3");
        idle(5, 1, "recall_ticks");
        step(1, 0, 0, 0, 1, 0, "reset_in_recall");
        idle(3, 1, "after_reset");

        for (int i = 0; i < 3000; i++) begin
            logic r, s, l, c, t, o;
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 1) == 0);
            o = !s && ($urandom_range(0, 59) == 0);
            step(r, s, l, c, t, o, "random");
        end

        @(negedge clk_50M);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode controller for the stopwatch counter/lap-register datapath.
- Converts debounced single-cycle button pulses (start/stop, lap, clear) into the datapath's run enable, clear strobe, lap-capture strobe/slot and display-source select.
- Also implements a lap-recall browsing mode with auto-return timeout.
- Sits between the debounce/pulse logic and the counter datapath; the whole block is in the clk_50M domain.

Parameters:
- NUM_LAPS, 3, number of lap slots; fixed at 3 for this revision; lap_slot and disp_sel are 2 bits.
- RECALL_TIMEOUT, 300, centisecond ticks of inactivity in RECALL before returning to the live display (3 s).
- TMR_W, $clog2(RECALL_TIMEOUT+1), recall timer width (derived, not overridden).

Ports:
- clk_50M  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- btn_start  in  1  one-cycle pulse, start/stop toggle
- btn_lap  in  1  one-cycle pulse, lap capture / recall step
- btn_clear  in  1  one-cycle pulse, clear
- tick_cs  in  1  one-cycle pulse every 0.01 s from the datapath prescaler
- ovf  in  1  one-cycle pulse: datapath count wrapped past 8:59.99
- run  out  1  datapath count enable
- clear_dp  out  1  one-cycle pulse: zero the count and all lap registers
- lap_we  out  1  one-cycle pulse: capture the live count into slot lap_slot
- lap_slot  out  2  slot index for lap_we (0..2)
- disp_sel  out  2  display source: 0 = live, 1..3 = lap slot 1..3
- laps_used  out  2  number of filled slots (0..3)
- lap_full  out  1  high when laps_used == NUM_LAPS

Behaviour:
- All outputs are registered; the response appears the cycle after the input pulse.
- Reset values: state IDLE, run 0, clear_dp 0, lap_we 0, lap_slot 0, disp_sel 0, laps_used 0, recall timer 0.
- Button priority when pulses coincide: clear > start > lap. Only the highest-priority valid button acts. A lower-priority pulse that is ignored in the current state does not block it.
- IDLE: run=0, disp_sel=0.
  - start -> RUNNING.
  - clear -> clear_dp pulse, stay IDLE.
  - lap ignored.
- RUNNING: run=1, disp_sel=0.
  - start -> PAUSED.
  - lap with laps_used<3 -> lap_we=1 and lap_slot=laps_used for one cycle; laps_used increments in the same cycle.
  - lap with laps_used==3 -> ignored, no lap_we.
  - clear ignored.
  - ovf -> PAUSED. ovf takes precedence over a start in the same cycle; the result is PAUSED either way. A lap in the same cycle as ovf is still captured.
- PAUSED: run=0, disp_sel=0.
  - start -> RUNNING.
  - clear -> IDLE, clear_dp pulse, laps_used=0.
  - lap with laps_used>0 -> RECALL, disp_sel=1, timer=0.
  - lap with laps_used==0 -> ignored.
- RECALL: run=0, disp_sel = current slot (1..laps_used).
  - lap: if disp_sel<laps_used then disp_sel+1 and timer=0; else PAUSED with disp_sel=0.
  - start -> RUNNING, disp_sel=0.
  - clear -> IDLE, clear_dp, laps_used=0, disp_sel=0.
  - Each tick_cs increments the timer. When the timer reaches RECALL_TIMEOUT-1 and a tick arrives -> PAUSED, disp_sel=0, timer=0. A button in that same cycle takes precedence over the timeout.
  - Timer is held at 0 outside RECALL.
- clear_dp and lap_we are never asserted together. lap_we is never asserted outside RUNNING.
- laps_used saturates at 3; it changes only via lap capture (+1) or clear/reset (to 0).
- Reset mid-operation (any state, any cycle): the reset values above apply on the next edge. Button pulses in the reset cycle are discarded.
- State encoding: IDLE=0, RUNNING=1, PAUSED=2, RECALL=3; 2-bit state register.

Decomposition:
- Shared package stopwatch_pkg:
  - sw_state_t enum (IDLE, RUNNING, PAUSED, RECALL).
  - disp_sel constants DISP_LIVE=0, DISP_LAP1..DISP_LAP3.
  - NUM_LAPS=3.
  - The same package is used by the datapath for disp_sel decoding.
- One sub-module: recall_timer.
  - TMR_W-bit counter with clear, tick enable and one-cycle expire output.
  - Instantiated once; the FSM and output registers stay in stopwatch_ctrl.

Test Plan:
- Reset, then btn_start -> run=1 on the next cycle. After 2nd btn_start -> run=0, state PAUSED. 3rd btn_start -> run=1 again.
- RUNNING, four btn_lap pulses 10 cycles apart:
  - First three produce lap_we with lap_slot 0,1,2 and laps_used 1,2,3.
  - Fourth produces no lap_we, lap_full=1.
- PAUSED with laps_used=2, btn_lap x3 -> disp_sel 1, 2, then 0 with state PAUSED. btn_clear -> clear_dp one cycle, laps_used=0, state IDLE.
- RECALL at disp_sel=1 with no buttons:
  - 299 tick_cs keep disp_sel=1; the 300th returns disp_sel=0, PAUSED.
  - Repeat with btn_lap on the 299th tick: timer restarts and disp_sel=2.
- RUNNING, btn_clear+btn_start+btn_lap in the same cycle:
  - clear is ignored (running), so start acts -> PAUSED; no lap_we.
  - In PAUSED, the same triple -> IDLE with clear_dp=1.
- RUNNING with an ovf pulse -> run=0, PAUSED next cycle. Assert reset while in RECALL -> all outputs at reset values on the next edge, tick_cs ignored.
